// File: rtl/eth_tx_arbiter_if.sv
// rtl/eth_tx_arbiter_if.sv - AXI-Stream bundle shared by the TX arbiter sources and MAC port
//   tvalid/tready : beat handshake
//   tdata/tkeep   : payload and byte enables
//   tlast/tuser   : end of packet, error/abort marker
//   master        : drives the beat, samples tready
//   slave         : samples the beat, drives tready
interface eth_tx_arbiter_if #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) ();
  logic                    tvalid;
  logic                    tready;
  logic [C_DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0]   tkeep;
  logic                    tlast;
  logic                    tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - packet-granular round-robin arbiter sharing the MAC TX stream
//   clk156    : core clock
//   eth_rst   : synchronous active-high reset
//   s_axis_a  : requester A (forwarded traffic)
//   s_axis_b  : requester B (locally generated packets)
//   m_axis_tx : stream to the MAC
//   grant     : one-hot owner {B,A}, 00 while idle
//   pkt_cnt_a : packets completed from A, wrapping
//   pkt_cnt_b : packets completed from B, wrapping
//   abort_cnt : packets aborted by the stall watchdog, saturating
module eth_tx_arbiter #(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int TIMEOUT      = 1024
) (
  input  logic             clk156,
  input  logic             eth_rst,
  eth_tx_arbiter_if.slave  s_axis_a,
  eth_tx_arbiter_if.slave  s_axis_b,
  eth_tx_arbiter_if.master m_axis_tx,
  output logic [1:0]       grant,
  output logic [31:0]      pkt_cnt_a,
  output logic [31:0]      pkt_cnt_b,
  output logic [15:0]      abort_cnt
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ABORT, ST_DROP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;            // 0 = A, 1 = B
  logic        last_grant_q, last_grant_d;
  logic [15:0] stall_q, stall_d;
  logic [31:0] pkt_a_q, pkt_a_d;
  logic [31:0] pkt_b_q, pkt_b_d;
  logic [15:0] abort_q, abort_d;

  logic                    src_tvalid;
  logic                    src_tlast;
  logic                    src_tuser;
  logic [C_DATA_WIDTH-1:0] src_tdata;
  logic [KEEP_WIDTH-1:0]   src_tkeep;
  logic                    src_tready;

  logic                    m_tvalid;
  logic [C_DATA_WIDTH-1:0] m_tdata;
  logic [KEEP_WIDTH-1:0]   m_tkeep;
  logic                    m_tlast;
  logic                    m_tuser;

  // Owner view of the two sources; only meaningful outside IDLE.
  assign src_tvalid = owner_q ? s_axis_b.tvalid : s_axis_a.tvalid;
  assign src_tlast  = owner_q ? s_axis_b.tlast  : s_axis_a.tlast;
  assign src_tuser  = owner_q ? s_axis_b.tuser  : s_axis_a.tuser;
  assign src_tdata  = owner_q ? s_axis_b.tdata  : s_axis_a.tdata;
  assign src_tkeep  = owner_q ? s_axis_b.tkeep  : s_axis_a.tkeep;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    stall_d      = stall_q;
    pkt_a_d      = pkt_a_q;
    pkt_b_d      = pkt_b_q;
    abort_d      = abort_q;
    src_tready   = 1'b0;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tkeep      = '0;
    m_tlast      = 1'b0;
    m_tuser      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_a.tvalid || s_axis_b.tvalid) begin
          // On a tie the source that did not go last wins.
          if (s_axis_a.tvalid && s_axis_b.tvalid) owner_d = ~last_grant_q;
          else                                     owner_d = s_axis_b.tvalid;
          stall_d = '0;
          state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        m_tvalid   = src_tvalid;
        m_tdata    = src_tdata;
        m_tkeep    = src_tkeep;
        m_tlast    = src_tlast;
        m_tuser    = src_tuser;
        src_tready = m_axis_tx.tready;
        if (src_tvalid && m_axis_tx.tready && src_tlast) begin
          if (owner_q) pkt_b_d = pkt_b_q + 32'd1;
          else         pkt_a_d = pkt_a_q + 32'd1;
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end else if (src_tvalid) begin
          // MAC backpressure is not a source stall.
          stall_d = '0;
        end else begin
          stall_d = stall_q + 16'd1;
          if (stall_d == TIMEOUT_C) state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        m_tkeep  = KEEP_WIDTH'(1);
        if (m_axis_tx.tready) begin
          if (abort_q != 16'hFFFF) abort_d = abort_q + 16'd1;
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        // Swallow the rest of the broken packet without forwarding it.
        src_tready = 1'b1;
        if (src_tvalid && src_tlast) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      stall_q      <= '0;
      pkt_a_q      <= '0;
      pkt_b_q      <= '0;
      abort_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      stall_q      <= stall_d;
      pkt_a_q      <= pkt_a_d;
      pkt_b_q      <= pkt_b_d;
      abort_q      <= abort_d;
    end
  end

  assign s_axis_a.tready  = src_tready && !owner_q;
  assign s_axis_b.tready  = src_tready && owner_q;
  assign m_axis_tx.tvalid = m_tvalid;
  assign m_axis_tx.tdata  = m_tdata;
  assign m_axis_tx.tkeep  = m_tkeep;
  assign m_axis_tx.tlast  = m_tlast;
  assign m_axis_tx.tuser  = m_tuser;

  assign grant     = (state_q == ST_IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);
  assign pkt_cnt_a = pkt_a_q;
  assign pkt_cnt_b = pkt_b_q;
  assign abort_cnt = abort_q;

endmodule
